// File: rtl/sched_pkg.sv
// Shared definitions for the round scheduler: FSM state encoding and default widths.
package sched_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam int DIM_W_DEFAULT = 8;
    localparam int PERF_W        = 16;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CLEAR   = 4'd1,
        ADVANCE = 4'd2,
        PLACE   = 4'd3,
        BCAST   = 4'd4,
        BWAIT   = 4'd5,
        DRAIN   = 4'd6,
        NEXT    = 4'd7,
        FINISH  = 4'd8
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/round_scheduler.sv
// Sequences positioner clear/advance, pixel broadcast and accumulator drain for every filter of a layer.
// Defining ROUND_SCHED_PERF_EN adds the perf_rounds / perf_stall counters.
module round_scheduler
    import sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DIM_W = DIM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_image_dim,
    input  logic [1:0]       cfg_padding,
    input  logic [2:0]       cfg_stride,
    input  logic [CNT_W-1:0] cfg_num_filters,
    output logic [DIM_W-1:0] image_dim,
    output logic [1:0]       padding,
    output logic [2:0]       stride,
    output logic             pos_rst,
    output logic             advance,
    input  logic             pos_round,
    input  logic             pos_done,
    output logic             bcast_start,
    input  logic             bcast_done,
    output logic             drain_req,
    input  logic             drain_ack,
    output logic [CNT_W-1:0] filter_idx,
    output logic [CNT_W-1:0] round_idx,
    output logic             busy,
    output logic             all_done
`ifdef ROUND_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_rounds,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    state_t           state_reg;
    state_t           state_next;
    logic [DIM_W-1:0] image_dim_reg;
    logic [1:0]       padding_reg;
    logic [2:0]       stride_reg;
    logic [CNT_W-1:0] num_filters_reg;
    logic [CNT_W-1:0] filter_idx_reg;
    logic             accept;
    logic             last_filter;
    logic             round_clr;
    logic             round_en;

    assign accept      = (state_reg == IDLE) && start;
    // One extra bit so filter_idx+1 cannot wrap when the count is all-ones.
    assign last_filter = (({1'b0, filter_idx_reg} + (CNT_W+1)'(1)) >= {1'b0, num_filters_reg});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = ADVANCE;
            ADVANCE: state_next = PLACE;
            PLACE:   if (pos_round) state_next = BCAST;
            // A done pulse coincident with the start pulse skips the wait state.
            BCAST:   state_next = bcast_done ? DRAIN : BWAIT;
            BWAIT:   if (bcast_done) state_next = DRAIN;
            DRAIN:   if (drain_ack) state_next = pos_done ? NEXT : ADVANCE;
            NEXT:    state_next = last_filter ? FINISH : CLEAR;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            image_dim_reg   <= '0;
            padding_reg     <= '0;
            stride_reg      <= '0;
            num_filters_reg <= '0;
        end else if (accept) begin
            image_dim_reg   <= cfg_image_dim;
            padding_reg     <= cfg_padding;
            stride_reg      <= cfg_stride;
            num_filters_reg <= (cfg_num_filters == '0) ? CNT_W'(1) : cfg_num_filters;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filter_idx_reg <= '0;
        end else if (accept) begin
            filter_idx_reg <= '0;
        end else if ((state_reg == NEXT) && !last_filter) begin
            filter_idx_reg <= filter_idx_reg + 1'b1;
        end
    end

    assign round_clr = accept || ((state_reg == NEXT) && !last_filter);
    assign round_en  = (state_reg == DRAIN) && drain_ack && !pos_done;

    sat_counter #(
        .W(CNT_W)
    ) u_round_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (round_clr),
        .en   (round_en),
        .count(round_idx)
    );

    assign image_dim   = image_dim_reg;
    assign padding     = padding_reg;
    assign stride      = stride_reg;
    assign filter_idx  = filter_idx_reg;
    assign pos_rst     = (state_reg == CLEAR);
    assign advance     = (state_reg == ADVANCE);
    assign bcast_start = (state_reg == BCAST);
    assign drain_req   = (state_reg == DRAIN);
    assign all_done    = (state_reg == FINISH);
    assign busy        = (state_reg != IDLE);

`ifdef ROUND_SCHED_PERF_EN
    logic [1:0]        perf_en;
    logic [PERF_W-1:0] perf_count [2];

    // Each ADVANCE begins a round; stall time is everything spent waiting on other blocks.
    assign perf_en[0] = (state_reg == ADVANCE);
    assign perf_en[1] = (state_reg == PLACE) || (state_reg == BWAIT) || (state_reg == DRAIN);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(
                .W(PERF_W)
            ) u_perf_cnt (
                .clk  (clk),
                .rst  (rst),
                .clr  (accept),
                .en   (perf_en[gi]),
                .count(perf_count[gi])
            );
        end
    endgenerate

    assign perf_rounds = perf_count[0];
    assign perf_stall  = perf_count[1];
`endif

endmodule

// File: tb/tb_round_scheduler.sv
// Scoreboard bench for round_scheduler: a randomized positioner/broadcast/drain responder plus a layer-level event model.
`timescale 1ns/1ps
module tb_round_scheduler;

    localparam int CNT_W = 8;
    localparam int DIM_W = 8;
    localparam int K_PRST = 0, K_ADV = 1, K_BC = 2, K_DRN = 3, K_DONE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] cfg_image_dim = '0;
    logic [1:0]       cfg_padding = '0;
    logic [2:0]       cfg_stride = '0;
    logic [CNT_W-1:0] cfg_num_filters = '0;
    logic [DIM_W-1:0] image_dim;
    logic [1:0]       padding;
    logic [2:0]       stride;
    logic             pos_rst, advance, bcast_start, drain_req, busy, all_done;
    logic             pos_round = 1'b0, pos_done = 1'b0, bcast_done = 1'b0, drain_ack = 1'b0;
    logic [CNT_W-1:0] filter_idx, round_idx;
`ifdef ROUND_SCHED_PERF_EN
    logic [15:0]      perf_rounds, perf_stall;
`endif

    round_scheduler #(.CNT_W(CNT_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_image_dim(cfg_image_dim), .cfg_padding(cfg_padding),
        .cfg_stride(cfg_stride), .cfg_num_filters(cfg_num_filters),
        .image_dim(image_dim), .padding(padding), .stride(stride),
        .pos_rst(pos_rst), .advance(advance), .pos_round(pos_round), .pos_done(pos_done),
        .bcast_start(bcast_start), .bcast_done(bcast_done),
        .drain_req(drain_req), .drain_ack(drain_ack),
        .filter_idx(filter_idx), .round_idx(round_idx),
        .busy(busy), .all_done(all_done)
`ifdef ROUND_SCHED_PERF_EN
        , .perf_rounds(perf_rounds), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int filt;
        int rnd;
        int dim;
        int pad;
        int str;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  start_cyc = 0, last_ack_cyc = 0, last_prst_cyc = 0, last_bdone_cyc = 0;
    int  done_seen = 0, bcast_seen = 0;
    int  plan_rounds[4];
    bit  fix_mode = 1'b0;
    int  fix_dp = 1, fix_db = 0, fix_dd = 0;
    int  env_filter = -1, env_placed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic string kname(int k);
        case (k)
            K_PRST:  return "pos_rst";
            K_ADV:   return "advance";
            K_BC:    return "bcast_start";
            K_DRN:   return "drain_req";
            K_DONE:  return "all_done";
            default: return "none";
        endcase
    endfunction

    function automatic longint outvec();
        return longint'({busy, pos_rst, advance, bcast_start, drain_req, all_done,
                         filter_idx, round_idx, image_dim, padding, stride});
    endfunction

    // Layer model: every filter is a clear, then one advance/broadcast/drain triple per round.
    task automatic push_plan(int eff, int dim, int pad, int str);
        ev_t e;
        e.dim = dim; e.pad = pad; e.str = str;
        for (int f = 0; f < eff; f++) begin
            e.kind = K_PRST; e.filt = f; e.rnd = 0; exp_q.push_back(e);
            for (int r = 0; r < plan_rounds[f]; r++) begin
                e.rnd = r;
                e.kind = K_ADV; exp_q.push_back(e);
                e.kind = K_BC;  exp_q.push_back(e);
                e.kind = K_DRN; exp_q.push_back(e);
            end
        end
        e.kind = K_DONE; e.filt = eff - 1; e.rnd = plan_rounds[eff-1] - 1;
        exp_q.push_back(e);
    endtask

    // Monitor: observes pulses mid-cycle, pops the scoreboard and checks indices and latencies.
    bit prev_drain = 1'b0;
    always @(negedge clk) begin : mon
        ev_t e;
        int  kind;
        bit  hit;
        if (!rst) begin
            prev_drain = 1'b0;
        end else begin
            hit = 1'b1;
            kind = -1;
            if (pos_rst)                       kind = K_PRST;
            else if (advance)                  kind = K_ADV;
            else if (bcast_start)              kind = K_BC;
            else if (drain_req && !prev_drain) kind = K_DRN;
            else if (all_done)                 kind = K_DONE;
            else                               hit = 1'b0;
            if (hit) begin
                if (kind == K_DONE) done_seen++;
                if (kind == K_BC) bcast_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %s, required none", kname(kind));
                end else begin
                    e = exp_q.pop_front();
                    chk({"event_kind_", kname(e.kind)}, kind, e.kind);
                    chk("filter_idx", filter_idx, e.filt);
                    chk("round_idx", round_idx, e.rnd);
                    case (e.kind)
                        K_PRST: begin
                            chk("image_dim", image_dim, e.dim);
                            chk("padding", padding, e.pad);
                            chk("stride", stride, e.str);
                            if (e.filt == 0) chk("start_to_pos_rst", cyc - start_cyc, 1);
                            else             chk("ack_to_pos_rst", cyc - last_ack_cyc, 2);
                            last_prst_cyc = cyc;
                        end
                        K_ADV: begin
                            if (e.rnd == 0) chk("pos_rst_to_advance", cyc - last_prst_cyc, 1);
                            else            chk("ack_to_advance", cyc - last_ack_cyc, 1);
                        end
                        K_DRN:  chk("bcast_done_to_drain", cyc - last_bdone_cyc, 1);
                        K_DONE: chk("ack_to_all_done", cyc - last_ack_cyc, 2);
                        default: ;
                    endcase
                end
            end
            prev_drain = drain_req;
            if (bcast_done) last_bdone_cyc = cyc;
            if (drain_req && drain_ack) last_ack_cyc = cyc;
        end
    end

    // Responder standing in for positioner, broadcast stage and DSP drain.
    int  p_cnt = 0, b_cnt = 0, d_cnt = 0;
    bit  env_prev_drain = 1'b0;
    initial begin : env
        int d;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                pos_round = 0; pos_done = 0; bcast_done = 0; drain_ack = 0;
                p_cnt = 0; b_cnt = 0; d_cnt = 0; env_prev_drain = 0;
            end else begin
                bcast_done = 0;
                drain_ack = 0;
                if (p_cnt == 1) begin
                    pos_round = 1;
                    env_placed++;
                    if (env_placed >= plan_rounds[env_filter]) pos_done = 1;
                    p_cnt = 0;
                end else if (p_cnt > 1) p_cnt--;
                if (b_cnt == 1) begin bcast_done = 1; b_cnt = 0; end
                else if (b_cnt > 1) b_cnt--;
                if (d_cnt == 1) begin drain_ack = 1; d_cnt = 0; end
                else if (d_cnt > 1) d_cnt--;
                if (pos_rst) begin
                    env_filter++; env_placed = 0; pos_done = 0; pos_round = 0;
                end
                if (advance) begin
                    pos_round = 0;
                    p_cnt = fix_mode ? fix_dp : int'($urandom_range(1, 4));
                end
                if (bcast_start) begin
                    d = fix_mode ? fix_db : int'($urandom_range(0, 5));
                    if (d == 0) bcast_done = 1; else b_cnt = d;
                end
                if (drain_req && !env_prev_drain) begin
                    d = fix_mode ? fix_dd : int'($urandom_range(0, 3));
                    if (d == 0) drain_ack = 1; else d_cnt = d;
                end
                env_prev_drain = drain_req;
            end
        end
    end

    task automatic run_job(int nf);
        int eff, dim, pad, str, d0, n;
        eff = (nf == 0) ? 1 : nf;
        dim = $urandom_range(1, 255);
        pad = $urandom_range(0, 3);
        str = $urandom_range(1, 7);
        env_filter = -1;
        env_placed = 0;
        push_plan(eff, dim, pad, str);
        d0 = done_seen;
        @(posedge clk); #1;
        cfg_image_dim = DIM_W'(dim); cfg_padding = 2'(pad); cfg_stride = 3'(str);
        cfg_num_filters = CNT_W'(nf); start = 1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        cfg_image_dim = DIM_W'($urandom); cfg_padding = 2'($urandom); cfg_stride = 3'($urandom);
        n = 0;
        while (done_seen == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("all_done_count", done_seen - d0, 1);
        @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_after_done", busy, 0);
        chk("filter_idx_hold", filter_idx, eff - 1);
        chk("round_idx_hold", round_idx, plan_rounds[eff-1] - 1);
        exp_q.delete();
        $display("job: cfg_num_filters=%0d rounds=%0d/%0d/%0d cycles=%0d", nf,
                 plan_rounds[0], plan_rounds[1], plan_rounds[2], n);
    endtask

    initial begin : stim
        int b0, n, dim;
        for (int i = 0; i < 4; i++) plan_rounds[i] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outvec(), 0);
        @(posedge clk); #1;
        rst = 1;

        // Single filter, one round, fixed handshake delays.
        fix_mode = 1; fix_dp = 3; fix_db = 5; fix_dd = 0;
        plan_rounds[0] = 1;
        run_job(1);

        // Three rounds in one layer.
        fix_mode = 0;
        plan_rounds[0] = 3;
        run_job(1);

        // Three filters, then a zero filter count.
        plan_rounds[0] = 2; plan_rounds[1] = 1; plan_rounds[2] = 3;
        run_job(3);
        plan_rounds[0] = 2;
        run_job(0);

        // Broadcast completes in the same cycle it starts.
        fix_mode = 1; fix_dp = 1; fix_db = 0; fix_dd = 0;
        plan_rounds[0] = 2; plan_rounds[1] = 2;
        run_job(2);

        // Start while busy, then abort with reset in the broadcast wait.
        fix_mode = 1; fix_dp = 2; fix_db = 40; fix_dd = 0;
        plan_rounds[0] = 3;
        env_filter = -1; env_placed = 0;
        dim = 8'h5a;
        push_plan(1, dim, 1, 3);
        b0 = bcast_seen;
        @(posedge clk); #1;
        cfg_image_dim = 8'h5a; cfg_padding = 2'd1; cfg_stride = 3'd3;
        cfg_num_filters = 8'd1; start = 1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        cfg_image_dim = 8'ha5; cfg_padding = 2'd2; cfg_stride = 3'd6; start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("cfg_held_on_busy_start", image_dim, dim);
        n = 0;
        while (bcast_seen == b0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("bcast_before_abort", bcast_seen - b0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("abort_outputs", outvec(), 0);
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1;
        @(negedge clk);
        chk("idle_after_abort", outvec(), 0);
        $display("abort: second start ignored, reset asserted during broadcast wait");
        fix_mode = 0;
        plan_rounds[0] = 2;
        run_job(1);

`ifdef ROUND_SCHED_PERF_EN
        // Two rounds, ten stall cycles each (3 place + 5 wait + 2 drain).
        fix_mode = 1; fix_dp = 3; fix_db = 5; fix_dd = 1;
        plan_rounds[0] = 2;
        run_job(1);
        chk("perf_rounds", perf_rounds, 2);
        chk("perf_stall", perf_stall, 20);
        fix_mode = 0;
`endif

        // Randomized layers.
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 4; i++) plan_rounds[i] = $urandom_range(1, 4);
            run_job($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
